// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: R-type shift funct codes, shifter FSM states,
// internal shift-op encoding and funct decode helpers.
package alu_defs_pkg;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } shift_op_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);
  endfunction

  // Only meaningful when funct_legal() is true.
  function automatic shift_op_t funct_to_op(input logic [5:0] funct);
    shift_op_t op;
    case (funct)
      FUNCT_SRL: op = OP_SRL;
      FUNCT_SRA: op = OP_SRA;
      default:   op = OP_SLL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_step_1b.sv
// Combinational single-position shift used in the work-register feedback path.
module shift_step_1b
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] shifted
);

  // Shift by one bit: zero fill for logical shifts, sign fill for arithmetic.
  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = {value[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, value[WIDTH-1:1]};
      OP_SRA:  shifted = {value[WIDTH-1], value[WIDTH-1:1]};
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, one bit position per clock. Holds the
// control FSM, the work register, the shift counter and one result register
// per operation; each result register only changes when its own op completes.
module serial_shift_unit
  import alu_defs_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   sll_out,
  output logic [WIDTH-1:0]   srl_out,
  output logic [WIDTH-1:0]   sra_out
);

  state_t             state_reg, state_next;
  shift_op_t          op_reg, op_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic               err_reg, err_next;
  logic [WIDTH-1:0]   sll_reg, sll_next;
  logic [WIDTH-1:0]   srl_reg, srl_next;
  logic [WIDTH-1:0]   sra_reg, sra_next;
  logic [WIDTH-1:0]   stepped;
  logic [WIDTH-1:0]   final_value;

  shift_step_1b #(.WIDTH(WIDTH)) u_step (
    .value   (work_reg),
    .op      (op_reg),
    .shifted (stepped)
  );

  // State, operand and result registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_SLL;
      work_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      sll_reg   <= '0;
      srl_reg   <= '0;
      sra_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      sll_reg   <= sll_next;
      srl_reg   <= srl_next;
      sra_reg   <= sra_next;
    end
  end

  // Next-state logic. A zero shift amount still spends one SHIFT cycle
  // (passing work through unshifted) so latency is max(shamt,1) edges.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    err_next    = 1'b0;
    sll_next    = sll_reg;
    srl_next    = srl_reg;
    sra_next    = sra_reg;
    final_value = (cnt_reg == '0) ? work_reg : stepped;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (funct_legal(funct)) begin
            op_next    = funct_to_op(funct);
            work_next  = rt_data;
            cnt_next   = shamt;
            state_next = SHIFT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_reg <= SHAMT_W'(1)) begin
          work_next  = final_value;
          cnt_next   = '0;
          state_next = DONE;
          case (op_reg)
            OP_SRL:  srl_next = final_value;
            OP_SRA:  sra_next = final_value;
            default: sll_next = final_value;
          endcase
        end else begin
          work_next = stepped;
          cnt_next  = cnt_reg - SHAMT_W'(1);
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == SHIFT) || (state_reg == DONE);
  assign done    = (state_reg == DONE);
  assign err     = err_reg;
  assign sll_out = sll_reg;
  assign srl_out = srl_reg;
  assign sra_out = sra_reg;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: a timing/arithmetic model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_serial_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rt_data = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        busy, done, err;
  logic [31:0] sll_out, srl_out, sra_out;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct   (funct),
    .rt_data (rt_data),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .sll_out (sll_out),
    .srl_out (srl_out),
    .sra_out (sra_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 working (finishes at edge fin), 2 done cycle.
  int          cyc = 0;
  int          phase = 0;
  int          fin = 0;
  logic [5:0]  m_funct = 6'd0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] e_sll = 32'd0, e_srl = 32'd0, e_sra = 32'd0;
  bit          e_err = 1'b0;

  function automatic logic [31:0] shift_result(input logic [5:0] f, input logic [31:0] d,
                                               input logic [4:0] s);
    logic [31:0] r;
    case (f)
      6'b000000: r = d << s;
      6'b000010: r = d >> s;
      default:   r = 32'($signed(d) >>> s);
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    e_err = 1'b0;
    if (reset) begin
      phase = 0;
      e_sll = 0; e_srl = 0; e_sra = 0;
    end else begin
      case (phase)
        2: phase = 0;
        1: if (cyc == fin) begin
             if (m_funct == 6'b000000) e_sll = m_res;
             else if (m_funct == 6'b000010) e_srl = m_res;
             else e_sra = m_res;
             phase = 2;
           end
        default: if (start) begin
             if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011) begin
               m_funct = funct;
               m_res   = shift_result(funct, rt_data, shamt);
               fin     = cyc + ((shamt == 0) ? 1 : int'(shamt));
               phase   = 1;
             end else begin
               e_err = 1'b1;
             end
           end
      endcase
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("busy", {31'd0, busy}, {31'd0, phase != 0});
      check("done", {31'd0, done}, {31'd0, phase == 2});
      check("err", {31'd0, err}, {31'd0, e_err});
      check("sll_out", sll_out, e_sll);
      check("srl_out", srl_out, e_srl);
      check("sra_out", sra_out, e_sra);
    end
  end

  // Issue one op at a negedge, scramble inputs mid-op, wait (bounded) for done,
  // then step into the first IDLE cycle. lat = edge index at which done follows.
  task automatic do_op(input logic [5:0] f, input logic [31:0] d, input logic [4:0] s,
                       output int lat, output int busy_cycles);
    start = 1'b1; funct = f; rt_data = d; shamt = s;
    @(negedge clk);
    start = 1'b0; rt_data = $urandom; shamt = 5'($urandom); funct = 6'($urandom_range(0, 3));
    lat = 0; busy_cycles = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cycles++;
    if (lat >= 100) check("done_timeout", 32'd0, 32'd1);
    $display("op funct=%b data=%h shamt=%0d lat=%0d busy=%0d sll=%h srl=%h sra=%h",
             f, d, s, lat, busy_cycles, sll_out, srl_out, sra_out);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc, dones;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_on = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sll", sll_out, 32'd0);

    // 1: SLL 1 by 4
    do_op(6'b000000, 32'h0000_0001, 5'd4, lat, bc);
    check("t1_lat", lat, 4);
    check("t1_sll", sll_out, 32'h0000_0010);
    check("t1_srl", srl_out, 32'd0);
    check("t1_sra", sra_out, 32'd0);

    // 2: SRA of min negative by 31
    do_op(6'b000011, 32'h8000_0000, 5'd31, lat, bc);
    check("t2_lat", lat, 31);
    check("t2_busy_cycles", bc, 32);
    check("t2_sra", sra_out, 32'hFFFF_FFFF);

    // 3: SRL by 0
    do_op(6'b000010, 32'hF000_000F, 5'd0, lat, bc);
    check("t3_lat", lat, 1);
    check("t3_srl", srl_out, 32'hF000_000F);

    // 4: illegal funct
    start = 1'b1; funct = 6'b100000; rt_data = 32'h1234_5678; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check("t4_err_pulse", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t4_err_clear", {31'd0, err}, 32'd0);
    check("t4_sll", sll_out, 32'h0000_0010);
    check("t4_srl", srl_out, 32'hF000_000F);
    check("t4_sra", sra_out, 32'hFFFF_FFFF);
    $display("illegal funct: err pulse seen, ports unchanged");

    // 5: SRL of all ones by 8, mid-op start re-pulse, reset at edge 3
    start = 1'b1; funct = 6'b000010; rt_data = 32'hFFFF_FFFF; shamt = 5'd8;
    @(negedge clk);
    funct = 6'b000000; rt_data = 32'h0000_00FF; shamt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_sll", sll_out, 32'd0);
    check("t5_srl", srl_out, 32'd0);
    check("t5_sra", sra_out, 32'd0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t5_no_done", dones, 0);
    $display("reset mid-op: outputs cleared, dones after reset=%0d", dones);

    // 6: back-to-back ops
    do_op(6'b000000, 32'd3, 5'd1, lat, bc);
    check("t6a_lat", lat, 1);
    do_op(6'b000011, 32'hFFFF_FF00, 5'd4, lat, bc);
    check("t6b_lat", lat, 4);
    check("t6_sll", sll_out, 32'd6);
    check("t6_sra", sra_out, 32'hFFFF_FFF0);
    check("t6_srl", srl_out, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
